wb_arbiter: RTL

Writeback arbiter that merges the single-cycle ALU result stream and the variable-latency load (LSU) result stream onto the register file's single write port. Load results the port cannot take immediately wait in a small in-order FIFO. The block tracks pending destinations for hazard checks at issue. It kills buffered load writes that a younger ALU write to the same register makes stale. It sits directly upstream of the register file and drives its write-enable, write-address and write-data inputs from registered outputs.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 83 ++++++++
 rtl/wb_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: register-file geometry and the writeback entry record.
package cpu_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
        logic [NREGS-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer of writeback entries with per-entry kill-by-destination.
// Latency: a pushed entry can be popped the cycle after the push.
// Backpressure: full is state-only; the caller must not push while full or pop while empty.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    input  logic                          kill_en,
    input  logic [REG_AW-1:0]             kill_rd,
    output wb_entry_t                     head,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  ent_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [DEPTH-1:0]  vld;
    logic [REG_AW-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign head.valid = vld[rd_ptr];
    assign head.rd    = rd_q[rd_ptr];
    assign head.data  = data_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Valid bits are cleared on pop so an unoccupied slot never reports a pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((pop && (PW'(i) == rd_ptr)) || (kill_en && (rd_q[i] == kill_rd)))
                    vld[i] <= 1'b0;
            end
            if (push) vld[wr_ptr] <= push_entry.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr]   <= push_entry.rd;
            data_q[wr_ptr] <= push_entry.data;
        end
    end

    always_comb begin
        ent_rd = '0;
        for (int i = 0; i < DEPTH; i++) ent_rd[i] = rd_q[i];
    end

    assign ent_valid = vld;

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and load results onto the single register-file write port (optional WB_STARVE_GUARD_EN).
// Latency: ALU 1 cycle; load 1 cycle via bypass, else >=1 cycle after reaching the buffer head.
// Backpressure: lsu_ready drops while the buffer is full; alu_stall rises only on a forced load slot.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_stall,
    input  logic              lsu_valid,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              lsu_ready,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_wa,
    output logic [XLEN-1:0]   wb_wd,
    output logic [NREGS-1:0]  pend_mask
);

    if (STARVE_LIMIT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    wb_entry_t                   head;
    wb_entry_t                   push_entry;
    logic                        full;
    logic                        empty;
    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH-1:0][REG_AW-1:0] ent_rd;

    logic lsu_acc;
    logic lsu_live;
    logic force_pop;
    logic alu_take;
    logic pop;
    logic bypass;
    logic push;
    logic kill_en;

    assign lsu_ready = !full;
    assign lsu_acc   = lsu_valid && !full;
    // Loads to x0 are accepted and dropped on the floor.
    assign lsu_live  = lsu_acc && (lsu_rd != '0);

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    assign force_pop = !empty && (starve_cnt == SW'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (empty || pop)
            starve_cnt <= '0;
        else
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign force_pop = 1'b0;
`endif

    assign alu_stall = force_pop;
    assign alu_take  = alu_valid && !force_pop;
    assign pop       = force_pop || (!alu_valid && !empty);
    assign bypass    = !alu_valid && empty && lsu_live;
    assign push      = lsu_live && !bypass;
    assign kill_en   = alu_take && (alu_rd != '0);

    // A load arriving alongside an ALU write to the same register is the older one.
    assign push_entry.valid = !(kill_en && (lsu_rd == alu_rd));
    assign push_entry.rd    = lsu_rd;
    assign push_entry.data  = lsu_data;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (kill_en),
        .kill_rd    (alu_rd),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .ent_valid  (ent_valid),
        .ent_rd     (ent_rd)
    );

    // A killed head still pops but retires as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we <= 1'b0;
            wb_wa <= '0;
            wb_wd <= '0;
        end else if (pop) begin
            wb_we <= head.valid;
            wb_wa <= head.rd;
            wb_wd <= head.data;
        end else if (alu_take) begin
            wb_we <= (alu_rd != '0);
            wb_wa <= alu_rd;
            wb_wd <= alu_data;
        end else if (bypass) begin
            wb_we <= 1'b1;
            wb_wa <= lsu_rd;
            wb_wd <= lsu_data;
        end else begin
            wb_we <= 1'b0;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) pend_mask = pend_mask | rd_onehot(ent_rd[i]);
        end
        if (wb_we) pend_mask = pend_mask | rd_onehot(wb_wa);
        pend_mask[0] = 1'b0;
    end

endmodule
